// File: rtl/fpmac_pkg.sv
// Shared FP16 types and flag indices for the DARTS FP MAC cluster.
package fpmac_pkg;
   localparam int FP16_W  = 16;
   localparam int FLAGS_W = 6;

   localparam int FLG_SNAN = 5;
   localparam int FLG_QNAN = 4;
   localparam int FLG_INF  = 3;
   localparam int FLG_ZERO = 2;
   localparam int FLG_SUB  = 1;
   localparam int FLG_NORM = 0;

   typedef logic [FP16_W-1:0]  fp16_t;
   typedef logic [FLAGS_W-1:0] fpmul_flags_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer wins, with wrap.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               en_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [PTR_W-1:0]   ptr_nxt_o
);
   logic found;
   int   idx;

   always_comb begin
      grant_o   = '0;
      ptr_nxt_o = ptr_i;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_i) + k) % NUM_REQ;
         if (en_i && !found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
            ptr_nxt_o    = PTR_W'((idx + 1) % NUM_REQ);
         end
      end
   end
endmodule

// File: rtl/fpmult_rr_sched.sv
// Round-robin scheduler sharing one external FP16 multiplier; issue reg then result reg.
// Optional FPMULT_STATS_EN adds saturating op/stall/exception counters.
module fpmult_rr_sched
   import fpmac_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*FP16_W-1:0] req_a,
   input  logic [NUM_REQ*FP16_W-1:0] req_b,
   input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
   output logic [FP16_W-1:0]         mul_a,
   output logic [FP16_W-1:0]         mul_b,
   input  logic [FP16_W-1:0]         mul_p,
   input  logic [FLAGS_W-1:0]        mul_flags,
   output logic [NUM_REQ-1:0]        rsp_valid,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic [FP16_W-1:0]         rsp_p,
   output logic [FLAGS_W-1:0]        rsp_flags,
   output logic [TAG_W-1:0]          rsp_tag,
   output logic                      sticky_nan
`ifdef FPMULT_STATS_EN
   ,
   output logic [31:0]               stat_ops,
   output logic [31:0]               stat_stall,
   output logic [31:0]               stat_exc
`endif
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef struct packed {
      fp16_t             a;
      fp16_t             b;
      logic [TAG_W-1:0]  tag;
      logic [PTR_W-1:0]  src;
   } s1_t;

   typedef struct packed {
      fp16_t             p;
      fpmul_flags_t      flags;
      logic [TAG_W-1:0]  tag;
      logic [PTR_W-1:0]  src;
   } s2_t;

   logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   s1_t              s1_q, s1_d;
   s2_t              s2_q, s2_d;
   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_nxt, sel;
   logic             sticky_q, sticky_d;
   logic [NUM_REQ-1:0] grant;
   logic             s2_free, s1_free, s2_hs, hs;

   assign s2_hs   = s2_v_q & rsp_ready[s2_q.src];
   assign s2_free = !s2_v_q | rsp_ready[s2_q.src];
   assign s1_free = !s1_v_q | s2_free;
   assign hs      = |grant;

   // Grant is gated by reset so req_ready reads 0 while rst_n is low.
   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .req_i     (req_valid),
      .en_i      (s1_free & rst_n),
      .ptr_i     (ptr_q),
      .grant_o   (grant),
      .ptr_nxt_o (ptr_nxt)
   );

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) sel = PTR_W'(i);
   end

   always_comb begin
      s1_v_d   = s1_v_q;
      s1_d     = s1_q;
      s2_v_d   = s2_v_q;
      s2_d     = s2_q;
      ptr_d    = ptr_q;
      sticky_d = sticky_q | (s2_hs & (s2_q.flags[FLG_SNAN] | s2_q.flags[FLG_QNAN]));
      if (s2_free) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) s2_d = '{p: mul_p, flags: mul_flags, tag: s1_q.tag, src: s1_q.src};
      end
      if (s1_free) begin
         s1_v_d = hs;
         if (hs) s1_d = '{a:   req_a[int'(sel)*FP16_W +: FP16_W],
                          b:   req_b[int'(sel)*FP16_W +: FP16_W],
                          tag: req_tag[int'(sel)*TAG_W +: TAG_W],
                          src: sel};
      end
      if (hs) ptr_d = ptr_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q   <= 1'b0;
         s2_v_q   <= 1'b0;
         s1_q     <= '0;
         s2_q     <= '0;
         ptr_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         s1_v_q   <= s1_v_d;
         s2_v_q   <= s2_v_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         ptr_q    <= ptr_d;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++)
         rsp_valid[i] = s2_v_q & (s2_q.src == PTR_W'(i));
   end

   assign req_ready  = grant;
   assign mul_a      = s1_q.a;
   assign mul_b      = s1_q.b;
   assign rsp_p      = s2_q.p;
   assign rsp_flags  = s2_q.flags;
   assign rsp_tag    = s2_q.tag;
   assign sticky_nan = sticky_q;

`ifdef FPMULT_STATS_EN
   logic [31:0] ops_q, stall_q, exc_q;
   logic        exc_hit;

   assign exc_hit = s2_hs & (s2_q.flags[FLG_SNAN] | s2_q.flags[FLG_QNAN] | s2_q.flags[FLG_INF]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops_q   <= '0;
         stall_q <= '0;
         exc_q   <= '0;
      end else begin
         if (s2_hs && ops_q != '1)                 ops_q   <= ops_q + 32'd1;
         if (s2_v_q && !s2_free && stall_q != '1)  stall_q <= stall_q + 32'd1;
         if (exc_hit && exc_q != '1)               exc_q   <= exc_q + 32'd1;
      end
   end

   assign stat_ops   = ops_q;
   assign stat_stall = stall_q;
   assign stat_exc   = exc_q;
`endif
endmodule
